ctr_block_serializer: RTL and testbench
=======================================

CTR_BLOCK_SERIALIZER -- requirements
Module: ctr_block_serializer

Interface
REQ-001 Parameter NUM_BLOCKS, default 8, SHALL set the number of 128-bit blocks per message; text_in width is NUM_BLOCKS*128.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 text_in  input  NUM_BLOCKS*128  ciphertext message from the CTR encryption stage; block k = text_in[128k+127:128k].
REQ-005 len_bytes  input  8  valid message length in bytes, 0..NUM_BLOCKS*16.
REQ-006 load_valid  input  1  text_in/len_bytes are valid.
REQ-007 load_ready  output  1  block can accept a message.
REQ-008 out_data  output  128  current output block.
REQ-009 out_keep  output  16  byte-valid mask; bit i qualifies out_data[8i+7:8i].
REQ-010 out_idx  output  3  index of current block.
REQ-011 out_last  output  1  current block is the final block of the message.
REQ-012 out_valid  output  1  out_data/out_keep/out_idx/out_last are valid.
REQ-013 out_ready  input  1  downstream accepts the block.
REQ-014 done  output  1  one-cycle pulse after the final block is transferred.

Function
REQ-015 Two states SHALL exist: IDLE (load_ready=1, out_valid=0) and STREAM (load_ready=0, out_valid=1).
REQ-016 An accept is load_valid && load_ready; on accept, text_in and len_bytes SHALL be registered and later changes to them ignored.
REQ-017 Accept with len_bytes=0 SHALL be consumed with no output block and no done pulse; the state stays IDLE.
REQ-018 len_bytes > NUM_BLOCKS*16 SHALL be saturated to NUM_BLOCKS*16.
REQ-019 Accept with nonzero length SHALL move to STREAM; out_valid SHALL rise the cycle after accept (latency 1).
REQ-020 Block count N = ceil(len/16); blocks SHALL be emitted in order idx 0..N-1, block 0 first.
REQ-021 A transfer is out_valid && out_ready; on each transfer, out_idx SHALL increment by 1 the next cycle.
REQ-022 While out_valid=1 && out_ready=0, all out_* signals SHALL hold stable.
REQ-023 out_keep SHALL be 16'hFFFF for non-final blocks.
REQ-024 For the final block, out_keep SHALL have its low (len mod 16) bits set, or all 16 bits set when len mod 16 = 0.
REQ-025 out_last SHALL be 1 only when out_idx = N-1.
REQ-026 On the final transfer, the state SHALL return to IDLE the next cycle; load_ready SHALL be 1 and done SHALL pulse for exactly that one cycle.
REQ-027 A new accept SHALL be possible in the first IDLE cycle after done (no extra bubble).
REQ-028 load_valid asserted during STREAM SHALL be ignored; it is not queued.
REQ-029 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE with load_ready=1, out_valid=0, out_last=0, done=0, out_idx=0, out_keep=0 and out_data=0.
REQ-031 rst=1 during STREAM SHALL abort the message; untransferred blocks are discarded and done does not pulse.
REQ-032 rst takes priority over a simultaneous accept or transfer.

Configuration
REQ-033 Macro CTR_SER_ZERO_PAD_EN defined: bytes of out_data whose out_keep bit is 0 SHALL be driven as 8'h00.
REQ-034 Macro CTR_SER_ZERO_PAD_EN undefined: out_data SHALL pass the captured block bytes unmodified regardless of out_keep.

Verification
REQ-035 Full message: len=128, text_in block k = {16{8'(k)}}, out_ready=1 -> 8 consecutive transfers idx 0..7, keep=FFFF, last on idx 7, done 1 cycle later.
REQ-036 Partial message: len=20 -> 2 blocks; block 1 keep=16'h000F, last=1; with CTR_SER_ZERO_PAD_EN, out_data[127:32]=0.
REQ-037 Backpressure: out_ready toggling 1,0,0,1 -> data held stable while stalled, no block duplicated or skipped.
REQ-038 Zero/oversize length: len=0 -> no out_valid, load_ready stays 1; len=200 -> treated as 128, 8 blocks.
REQ-039 Reset mid-stream: rst pulsed after idx 3 transfer -> out_valid=0 next cycle, no done, new message starts at idx 0.
REQ-040 Back-to-back: load_valid held high across done -> second message accepted in the done cycle, its block 0 appears one cycle later.

Source files
------------

// File: rtl/ctr_block_serializer.sv
// Serializes a captured multi-block CTR ciphertext message into 128-bit beats with byte-keep masks.
// Optional CTR_SER_ZERO_PAD_EN: bytes outside the keep mask are forced to zero.
module ctr_block_serializer #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BLOCKS*128-1:0] text_in,
  input  logic [7:0]                len_bytes,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic [127:0]              out_data,
  output logic [15:0]               out_keep,
  output logic [2:0]                out_idx,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      done
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
  localparam int         MAX_LEN = NUM_BLOCKS * 16;

  logic [0:0]                   state_q;
  logic [NUM_BLOCKS-1:0][127:0] blk_q;
  logic [7:0]                   len_q;
  logic [2:0]                   idx_q;
  logic                         done_q;

  logic       streaming;
  logic [7:0] len_sat;
  logic [2:0] last_idx;
  logic       is_last;
  logic [15:0] keep_last, keep_cur;
  logic [127:0] raw, pad;

  assign streaming = (state_q == STREAM);
  assign len_sat   = (int'(len_bytes) > MAX_LEN) ? 8'(MAX_LEN) : len_bytes;
  // len_q is never zero while streaming, so (len-1)/16 is the final block index
  assign last_idx  = 3'((len_q - 8'd1) >> 4);
  assign is_last   = (idx_q == last_idx);

  always_comb begin
    keep_last = '0;
    for (int i = 0; i < 16; i++)
      keep_last[i] = (len_q[3:0] == 4'd0) || (4'(i) < len_q[3:0]);
  end

  assign keep_cur = is_last ? keep_last : 16'hFFFF;
  assign raw      = blk_q[idx_q];

`ifdef CTR_SER_ZERO_PAD_EN
  for (genvar i = 0; i < 16; i++) begin : g_pad
    assign pad[8*i +: 8] = keep_cur[i] ? raw[8*i +: 8] : 8'h00;
  end
`else
  assign pad = raw;
`endif

  assign load_ready = !streaming;
  assign out_valid  = streaming;
  assign out_data   = streaming ? pad : '0;
  assign out_keep   = streaming ? keep_cur : '0;
  assign out_last   = streaming && is_last;
  assign out_idx    = idx_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // zero-length loads are consumed silently
          if (load_valid && len_bytes != 8'd0) begin
            blk_q   <= text_in;
            len_q   <= len_sat;
            idx_q   <= '0;
            state_q <= STREAM;
          end
        end
        default: begin
          if (out_ready) begin
            if (is_last) begin
              state_q <= IDLE;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_block_serializer.sv
// Randomized self-checking bench for ctr_block_serializer against a byte-level message model.
module tb_ctr_block_serializer;
  localparam int NB = 8;
  localparam int TW = NB * 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] text_in;
  logic [7:0]    len_bytes;
  logic          load_valid;
  logic          load_ready;
  logic [127:0]  out_data;
  logic [15:0]   out_keep;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          done;

  int total = 0;
  int bad   = 0;

  ctr_block_serializer #(.NUM_BLOCKS(NB)) dut (
    .clk(clk), .rst(rst), .text_in(text_in), .len_bytes(len_bytes),
    .load_valid(load_valid), .load_ready(load_ready), .out_data(out_data),
    .out_keep(out_keep), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: byte g of the message is valid iff g < len ----------------
  function automatic int eff_len(input int len);
    return (len > NB * 16) ? NB * 16 : len;
  endfunction

  function automatic int nblocks(input int len);
    return (eff_len(len) + 15) / 16;
  endfunction

  function automatic logic [15:0] exp_keep(input int len, input int k);
    logic [15:0] m;
    for (int b = 0; b < 16; b++) m[b] = ((16 * k + b) < eff_len(len));
    return m;
  endfunction

  function automatic logic [127:0] exp_data(input logic [TW-1:0] t, input int len, input int k);
    logic [127:0] d;
    for (int b = 0; b < 16; b++) begin
      d[8*b +: 8] = t[8*(16*k + b) +: 8];
`ifdef CTR_SER_ZERO_PAD_EN
      if ((16 * k + b) >= eff_len(len)) d[8*b +: 8] = 8'h00;
`endif
    end
    return d;
  endfunction

  function automatic logic [TW-1:0] rand_text();
    logic [TW-1:0] t;
    for (int i = 0; i < TW / 32; i++) t[32*i +: 32] = $urandom;
    return t;
  endfunction

  // Present one message for a single edge, then scramble inputs to prove they were captured.
  task automatic load(input logic [TW-1:0] t, input int len);
    load_valid = 1'b1;
    text_in    = t;
    len_bytes  = 8'(len);
    @(negedge clk);
    load_valid = 1'b0;
    text_in    = rand_text();
    len_bytes  = 8'($urandom);
  endtask

  // Consume a streaming message; mode 0 = always ready, 1 = random, 2 = 1,0,0,1 pattern.
  task automatic drain(input logic [TW-1:0] t, input int len, input int mode, input string tag);
    int n, k, cyc;
    logic r;
    n = nblocks(len); k = 0; cyc = 0;
    while (k < n && cyc < 400) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin
        bad++;
        $display("FAIL %s vld/idx: got %b/%0d want 1/%0d", tag, out_valid, out_idx, k);
      end
      total++;
      if (out_data !== exp_data(t, len, k)) begin
        bad++;
        $display("FAIL %s data k=%0d: got %h want %h", tag, k, out_data, exp_data(t, len, k));
      end
      total++;
      if (out_keep !== exp_keep(len, k) || out_last !== (k == n - 1)) begin
        bad++;
        $display("FAIL %s keep/last k=%0d: got %h/%b want %h/%b", tag, k, out_keep, out_last,
                 exp_keep(len, k), (k == n - 1));
      end
      total++;
      if (done !== 1'b0 || load_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s busy flags: done=%b load_ready=%b want 0/0", tag, done, load_ready);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      out_ready = r;
      if (r) k++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL %s timeout: transferred %0d want %0d", tag, k, n);
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s done cycle: done=%b vld=%b rdy=%b want 1/0/1", tag, done, out_valid, load_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; out_ready = 1'b1; text_in = rand_text(); len_bytes = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({load_ready, out_valid, out_last, done, out_idx, out_keep} !== {4'b1000, 3'd0, 16'h0} ||
        out_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b last=%b done=%b idx=%0d keep=%h data=%h",
               load_ready, out_valid, out_last, done, out_idx, out_keep, out_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready_no_effect: vld=%b rdy=%b done=%b want 0/1/0", out_valid, load_ready, done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [TW-1:0] t;
    for (int k = 0; k < NB; k++) t[128*k +: 128] = {16{8'(k)}};
    load(t, 128);
    drain(t, 128, 0, "full");
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL full done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_partial();
    logic [TW-1:0] t;
    t = rand_text();
    load(t, 20);
    drain(t, 20, 0, "partial");
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] t;
    t = rand_text();
    load(t, 64);
    drain(t, 64, 2, "backpressure");
    @(negedge clk);
  endtask

  task automatic test_zero_oversize();
    logic [TW-1:0] t;
    load(rand_text(), 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL zero_len: vld=%b rdy=%b done=%b want 0/1/0", out_valid, load_ready, done);
      end
      @(negedge clk);
    end
    t = rand_text();
    load(t, 200);
    drain(t, 200, 0, "oversize");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] t;
    t = rand_text();
    load(t, 128);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (out_idx !== 3'd4 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid pre: idx=%0d vld=%b want 4/1", out_idx, out_valid);
    end
    rst = 1'b1;
    load_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || out_idx !== 3'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid post: vld=%b rdy=%b idx=%0d done=%b want 0/1/0/0",
               out_valid, load_ready, out_idx, done);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid no_done: done=%b vld=%b want 0/0", done, out_valid);
      end
    end
    t = rand_text();
    load(t, 48);
    drain(t, 48, 1, "after_rst");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] ta, tb;
    int la, lb;
    ta = rand_text(); tb = rand_text();
    la = 32; lb = $urandom_range(1, 128);
    load_valid = 1'b1; text_in = ta; len_bytes = 8'(la);
    @(negedge clk);
    // keep load_valid high with the second message; it must wait for the done cycle
    text_in = tb; len_bytes = 8'(lb);
    drain(ta, la, 0, "b2b_first");
    @(negedge clk);
    load_valid = 1'b0;
    text_in = rand_text();
    drain(tb, lb, 1, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [TW-1:0] t;
    int len;
    for (int m = 0; m < 25; m++) begin
      t = rand_text();
      len = $urandom_range(1, 255);
      load(t, len);
      drain(t, len, 1, "random");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full();
    test_partial();
    test_backpressure();
    test_zero_oversize();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
